shader_sequencer: RTL and testbench

Per-pixel sequencer and controller for the shader execute datapath.
- Holds a small writable program memory.
- On each pixel request, streams the program one instruction per cycle on instr_o with execute_o, holding pixel coordinates stable.
- Captures the resulting 6-bit colour and reports completion.
- Also generates the time0/time1 operands from frame pulses.
- Sits between the video timing/host load logic and the execute unit.

---
 rtl/shader_pkg.sv | 22 ++
 rtl/shader_time_counter.sv | 47 ++++
 rtl/shader_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_shader_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// ---------------------------------------------------------------------------
// shader_pkg
// Shared types and constants for the shader sequencer slice.
//   seq_state_t : sequencer states (IDLE, RUN, CAPTURE)
//   INSTR_W     : instruction word width
//   DATA_W      : colour / coordinate / time operand width
//   INSTR_END   : word treated as END when early termination is built in
// ---------------------------------------------------------------------------
package shader_pkg;

    localparam int INSTR_W = 8;
    localparam int DATA_W  = 6;

    localparam logic [INSTR_W-1:0] INSTR_END = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shader_time_counter.sv
// ---------------------------------------------------------------------------
// shader_time_counter
// 12-bit time base split into time1:time0 operands for the execute unit.
// The count only advances while the sequencer is idle so operands stay
// constant for the whole pixel; frames seen while busy are remembered in a
// single pending flag (several frames collapse into one step).
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   frame_i  : one-cycle frame pulse
//   busy_i   : sequencer is in RUN or CAPTURE
//   time0_o  : fast counter (low 6 bits)
//   time1_o  : slow counter (high 6 bits)
// ---------------------------------------------------------------------------
module shader_time_counter
    import shader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] time0_o,
    output logic [DATA_W-1:0] time1_o
);

    logic                  r_pending;
    logic [2*DATA_W-1:0]   r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
            r_count   <= '0;
        end else if (busy_i) begin
            if (frame_i) begin
                r_pending <= 1'b1;
            end
        end else if (frame_i | r_pending) begin
            // time0 carries into time1 and the whole thing wraps 4095 -> 0
            r_count   <= r_count + 1'b1;
            r_pending <= 1'b0;
        end
    end

    assign time0_o = r_count[DATA_W-1:0];
    assign time1_o = r_count[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/shader_sequencer.sv
// ---------------------------------------------------------------------------
// shader_sequencer
// Per-pixel controller for the shader execute datapath. Holds a writable
// program, streams it one word per cycle to the execute unit for every
// accepted pixel, captures the resulting colour and pulses done_o.
//
// Optional build macro: SHADER_SEQ_EARLY_END_EN
//   defined   : a word equal to INSTR_END at a non-zero pc ends the pixel
//               early (not executed; that cycle serves as the capture cycle)
//   undefined : every pixel runs all NUM_INSTR words
//
// Ports:
//   clk_i, rst_i              : clock / synchronous active-high reset
//   prog_we_i/addr_i/data_i   : program write port (ignored while busy)
//   start_i, x_i, y_i         : pixel request and coordinates
//   frame_i                   : frame pulse advancing the time operands
//   rgb_i                     : colour from the execute unit
//   busy_o                    : high in RUN and CAPTURE
//   instr_o, execute_o        : instruction stream to the execute unit
//   x_o, y_o                  : latched pixel coordinates
//   time0_o, time1_o          : time operands
//   rgb_o, done_o             : captured colour and one-cycle completion
//
// state   | meaning
// IDLE    | waiting for start_i; program writes and time updates allowed
// RUN     | streaming mem[pc] with execute_o high
// CAPTURE | rgb_i settled from last word; latch it and pulse done_o
// ---------------------------------------------------------------------------
module shader_sequencer
    import shader_pkg::*;
#(
    parameter  int NUM_INSTR = 8,
    localparam int ADDR_W    = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               prog_we_i,
    input  logic [ADDR_W-1:0]  prog_addr_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    input  logic               start_i,
    input  logic [DATA_W-1:0]  x_i,
    input  logic [DATA_W-1:0]  y_i,
    input  logic               frame_i,
    input  logic [DATA_W-1:0]  rgb_i,
    output logic               busy_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               execute_o,
    output logic [DATA_W-1:0]  x_o,
    output logic [DATA_W-1:0]  y_o,
    output logic [DATA_W-1:0]  time0_o,
    output logic [DATA_W-1:0]  time1_o,
    output logic [DATA_W-1:0]  rgb_o,
    output logic               done_o
);

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_INSTR - 1);
    localparam logic [ADDR_W:0]   LP_NUM  = (ADDR_W + 1)'(NUM_INSTR);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [INSTR_W-1:0]  r_mem [NUM_INSTR];
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_rgb;
    logic                r_done;

    logic                w_busy;
    logic [INSTR_W-1:0]  w_word;
    logic                w_end;
    logic                w_accept;
    logic                w_capture;
    logic                w_execute;
    logic [INSTR_W-1:0]  w_instr;
    logic                w_mem_we;

    assign w_busy = (r_state != IDLE);
    assign w_word = r_mem[r_pc];

`ifdef SHADER_SEQ_EARLY_END_EN
    // pc 0 is exempt so a program may legally start with the END encoding
    assign w_end = (w_word == INSTR_END) && (r_pc != '0);
`else
    assign w_end = 1'b0;
`endif

    // Out-of-range addresses can only occur when NUM_INSTR is not a power of 2
    assign w_mem_we = prog_we_i && !w_busy && ({1'b0, prog_addr_i} < LP_NUM);

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_execute    = 1'b0;
        w_instr      = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_pc_next    = '0;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_instr = w_word;
                if (w_end) begin
                    // Nothing executes this cycle, so rgb_i already reflects the
                    // previous word: capture here instead of spending a CAPTURE cycle.
                    w_capture    = 1'b1;
                    w_pc_next    = '0;
                    w_next_state = IDLE;
                end else begin
                    w_execute = 1'b1;
                    if (r_pc == LP_LAST) begin
                        w_pc_next    = '0;
                        w_next_state = CAPTURE;
                    end else begin
                        w_pc_next = r_pc + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_pc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_rgb   <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_INSTR; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_done  <= w_capture;
            if (w_capture) begin
                r_rgb <= rgb_i;
            end
            if (w_accept) begin
                r_x <= x_i;
                r_y <= y_i;
            end
            if (w_mem_we) begin
                r_mem[prog_addr_i] <= prog_data_i;
            end
        end
    end

    shader_time_counter u_time (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .frame_i (frame_i),
        .busy_i  (w_busy),
        .time0_o (time0_o),
        .time1_o (time1_o)
    );

    assign busy_o    = w_busy;
    assign instr_o   = w_instr;
    assign execute_o = w_execute;
    assign x_o       = r_x;
    assign y_o       = r_y;
    assign rgb_o     = r_rgb;
    assign done_o    = r_done;

endmodule

// File: tb/tb_shader_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shader_sequencer
// Directed and randomized stimulus for shader_sequencer, checked against a
// transaction-level model: a program array, a time count modulo 4096 with a
// pending flag, and the expected per-pixel schedule (start, run words,
// capture, done).
// ---------------------------------------------------------------------------
module tb_shader_sequencer;

    localparam int N = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       prog_we_i = 1'b0;
    logic [2:0] prog_addr_i = '0;
    logic [7:0] prog_data_i = '0;
    logic       start_i = 1'b0;
    logic [5:0] x_i = '0;
    logic [5:0] y_i = '0;
    logic       frame_i = 1'b0;
    logic [5:0] rgb_i = '0;
    logic       busy_o;
    logic [7:0] instr_o;
    logic       execute_o;
    logic [5:0] x_o;
    logic [5:0] y_o;
    logic [5:0] time0_o;
    logic [5:0] time1_o;
    logic [5:0] rgb_o;
    logic       done_o;

    shader_sequencer #(.NUM_INSTR(N)) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .prog_we_i   (prog_we_i),
        .prog_addr_i (prog_addr_i),
        .prog_data_i (prog_data_i),
        .start_i     (start_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .frame_i     (frame_i),
        .rgb_i       (rgb_i),
        .busy_o      (busy_o),
        .instr_o     (instr_o),
        .execute_o   (execute_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .time0_o     (time0_o),
        .time1_o     (time1_o),
        .rgb_o       (rgb_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_assert = 0;
    int         n_fail   = 0;

    logic [7:0] m_mem [N];
    int         m_time;
    bit         m_pend;
    logic [5:0] m_x, m_y, m_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are held across the edge and outputs sampled 1 after it.
    task automatic step(input bit busy);
        @(posedge clk_i);
        #1;
        if (busy) begin
            if (frame_i) m_pend = 1'b1;
        end else if (frame_i || m_pend) begin
            m_time = (m_time + 1) % 4096;
            m_pend = 1'b0;
        end
        chk("time", {20'd0, time1_o, time0_o}, 32'(m_time));
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_mem[i] = 8'h00;
        m_time = 0;
        m_pend = 1'b0;
        m_x = '0;
        m_y = '0;
        m_rgb = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        prog_we_i = 1'b0;
        frame_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_clear();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_exec", 32'(execute_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_instr", 32'(instr_o), 0);
        chk("rst_xy", {20'd0, x_o, y_o}, 0);
        chk("rst_rgb", 32'(rgb_o), 0);
        chk("rst_time", {20'd0, time1_o, time0_o}, 0);
    endtask

    task automatic idle(input int n, input int frame_pct);
        for (int i = 0; i < n; i++) begin
            start_i = 1'b0;
            prog_we_i = 1'b0;
            frame_i = ($urandom_range(99) < frame_pct);
            rgb_i = 6'($urandom);
            step(1'b0);
            chk("idle_busy", 32'(busy_o), 0);
            chk("idle_exec", 32'(execute_o), 0);
            chk("idle_done", 32'(done_o), 0);
            chk("idle_instr", 32'(instr_o), 0);
            chk("idle_rgb", 32'(rgb_o), 32'(m_rgb));
            chk("idle_x", 32'(x_o), 32'(m_x));
        end
        frame_i = 1'b0;
    endtask

    task automatic prog_write(input logic [2:0] a, input logic [7:0] d);
        start_i = 1'b0;
        frame_i = 1'b0;
        prog_we_i = 1'b1;
        prog_addr_i = a;
        prog_data_i = d;
        step(1'b0);
        m_mem[a] = d;
        prog_we_i = 1'b0;
        chk("wr_busy", 32'(busy_o), 0);
    endtask

    // Full pixel from the start cycle to the done cycle (returns sampling the
    // done cycle, so a following call starts a back-to-back pixel).
    task automatic do_pixel(input logic [5:0] x, input logic [5:0] y, input int nfr,
                            input bit wr_start, input bit wr_run,
                            input logic [2:0] wa, input logic [7:0] wd);
        int         len;
        logic [5:0] r;
        chk("x_before_accept", 32'(x_o), 32'(m_x));
        start_i = 1'b1;
        x_i = x;
        y_i = y;
        frame_i = 1'($urandom_range(1));
        rgb_i = 6'($urandom);
        prog_we_i = wr_start;
        prog_addr_i = wa;
        prog_data_i = wd;
        if (wr_start) m_mem[wa] = wd;
        len = N;
`ifdef SHADER_SEQ_EARLY_END_EN
        for (int k = N - 1; k >= 1; k--) if (m_mem[k] == 8'h00) len = k;
`endif
        step(1'b0);
        m_x = x;
        m_y = y;
        prog_we_i = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk("run_busy", 32'(busy_o), 1);
            chk("run_exec", 32'(execute_o), 1);
            chk("run_instr", 32'(instr_o), 32'(m_mem[k]));
            chk("run_xy", {20'd0, x_o, y_o}, {20'd0, m_x, m_y});
            chk("run_done", 32'(done_o), 0);
            start_i = 1'($urandom_range(1));
            x_i = 6'($urandom);
            y_i = 6'($urandom);
            frame_i = (k < nfr);
            rgb_i = 6'($urandom);
            prog_we_i = wr_run && (k == 2);
            prog_addr_i = wa;
            prog_data_i = ~wd;
            step(1'b1);
        end
        prog_we_i = 1'b0;
        chk("cap_busy", 32'(busy_o), 1);
        chk("cap_exec", 32'(execute_o), 0);
        chk("cap_instr", 32'(instr_o), 0);
        chk("cap_done", 32'(done_o), 0);
        r = 6'($urandom);
        rgb_i = r;
        start_i = 1'($urandom_range(1));
        frame_i = 1'b0;
        step(1'b1);
        m_rgb = r;
        start_i = 1'b0;
        chk("done_pulse", 32'(done_o), 1);
        chk("done_busy", 32'(busy_o), 0);
        chk("done_exec", 32'(execute_o), 0);
        chk("done_rgb", 32'(rgb_o), 32'(m_rgb));
        chk("done_xy", {20'd0, x_o, y_o}, {20'd0, m_x, m_y});
    endtask

    // Watches the DUT directly with a bounded cycle budget and checks the
    // execute-cycle count and the done cycle number relative to start.
    task automatic timed_pixel(input logic [5:0] x, input int exp_exec, input int exp_done);
        int n_exec;
        int done_at;
        start_i = 1'b1;
        x_i = x;
        y_i = 6'd0;
        frame_i = 1'b0;
        rgb_i = 6'h2A;
        step(1'b0);
        start_i = 1'b0;
        m_x = x;
        m_y = 6'd0;
        n_exec = 0;
        done_at = -1;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            if (execute_o) n_exec++;
            if (done_o) done_at = c;
            else step(1'b1);
        end
        if (done_at < 0) chk("done_timeout", 0, 1);
        m_rgb = 6'h2A;
        chk("exec_cycles", 32'(n_exec), 32'(exp_exec));
        chk("done_cycle", 32'(done_at), 32'(exp_done));
        chk("timed_rgb", 32'(rgb_o), 32'h2A);
        chk("timed_x", 32'(x_o), 32'(x));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        // 1: basic pixel
        do_reset();
        prog_write(3'd0, 8'h40);
        for (int i = 1; i < N; i++) prog_write(3'(i), 8'h00);
`ifdef SHADER_SEQ_EARLY_END_EN
        timed_pixel(6'd5, 1, 3);
`else
        timed_pixel(6'd5, 8, 10);
`endif
        idle(2, 0);
        do_pixel(6'd5, 6'd7, 0, 0, 0, 3'd0, 8'h00);

        // 2: back-to-back pixels
        for (int i = 0; i < N; i++) prog_write(3'(i), 8'(8'h81 + i));
        do_pixel(6'd11, 6'd12, 0, 0, 0, 3'd0, 8'h00);
        do_pixel(6'd21, 6'd22, 0, 0, 0, 3'd0, 8'h00);
        do_pixel(6'd31, 6'd32, 0, 0, 0, 3'd0, 8'h00);
        idle(1, 0);

        // 3: write blocked while busy, allowed in IDLE and at accepted start
        do_pixel(6'd1, 6'd2, 0, 0, 1, 3'd3, 8'h77);
        idle(1, 0);
        do_pixel(6'd3, 6'd4, 0, 0, 0, 3'd0, 8'h00);
        idle(1, 0);
        prog_write(3'd3, 8'h77);
        do_pixel(6'd5, 6'd6, 0, 0, 0, 3'd0, 8'h00);
        do_pixel(6'd7, 6'd8, 0, 1, 0, 3'd4, 8'h5C);
        idle(1, 0);

        // 4: time wrap and pending collapse
        do_reset();
        idle(64, 100);
        chk("time_64", {20'd0, time1_o, time0_o}, 32'h040);
        do_pixel(6'd9, 6'd9, 3, 0, 0, 3'd0, 8'h00);
        idle(3, 0);
        idle(4100, 100);
        idle(2, 0);

        // 5: reset in RUN cycle 4
        for (int i = 0; i < N; i++) prog_write(3'(i), 8'(8'h10 + i));
        start_i = 1'b1;
        x_i = 6'd33;
        frame_i = 1'b0;
        step(1'b0);
        start_i = 1'b0;
        m_x = 6'd33;
        m_y = y_i;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        chk("pre_rst_exec", 32'(execute_o), 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_clear();
        chk("midrst_exec", 32'(execute_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_done", 32'(done_o), 0);
        idle(12, 0);
        do_pixel(6'd2, 6'd3, 0, 0, 0, 3'd0, 8'h00);

        // 6: early end program
        prog_write(3'd0, 8'h41);
        prog_write(3'd1, 8'h42);
        for (int i = 2; i < N; i++) prog_write(3'(i), 8'h00);
`ifdef SHADER_SEQ_EARLY_END_EN
        timed_pixel(6'd12, 2, 4);
`else
        timed_pixel(6'd12, 8, 10);
`endif
        idle(1, 0);
        do_pixel(6'd13, 6'd14, 1, 0, 0, 3'd0, 8'h00);

        // randomized mix
        for (int t = 0; t < 30; t++) begin
            int nw;
            nw = $urandom_range(3);
            for (int w = 0; w < nw; w++) prog_write(3'($urandom), 8'($urandom));
            idle($urandom_range(2), 30);
            do_pixel(6'($urandom), 6'($urandom), $urandom_range(N), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 3'($urandom), 8'($urandom));
        end
        idle(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
